// File: rtl/ucode_mul_seq.sv
`default_nettype none
// ============================================================================
// ucode_mul_seq : expands MUL Rd,Rs,#imm into a MOV/ADD instruction stream
// Rev 1.0
// ============================================================================
module ucode_mul_seq #(
  parameter int          IMM_W       = 16,
  parameter int          MODE        = 0,
  parameter int          SCRATCH_REG = 15,
  parameter logic [6:0]  OPC_MOV     = 7'b0000000,
  parameter logic [6:0]  OPC_ADD     = 7'b0110001,
  parameter logic [31:0] NOP_WORD    = {5'b11001, 27'b0}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_ready,
  input  logic [3:0]       dest_reg,
  input  logic [3:0]       source_reg,
  input  logic [IMM_W-1:0] immediate,
  input  logic             flush,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             busy,
  output logic             done
);

  localparam int             KW      = (IMM_W > 1) ? $clog2(IMM_W) : 1;
  localparam logic [3:0]     SCR     = 4'(SCRATCH_REG);
  localparam logic [IMM_W-1:0] CNT_ONE = IMM_W'(1);
  localparam logic [KW-1:0]  K_ONE   = KW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CPY_CLR = 3'd1,
    S_CPY_ADD = 3'd2,
    S_CLR     = 3'd3,
    S_ADD     = 3'd4,
    S_ACC     = 3'd5,
    S_DBL     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       rd_q, rd_d;
  logic [3:0]       rs_q, rs_d;
  logic [3:0]       src_q, src_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [IMM_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             fire;

  function automatic logic [KW-1:0] msb_idx(input logic [IMM_W-1:0] v);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < IMM_W; i++) begin
      if (v[i]) r = KW'(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] mov_word(input logic [3:0] rd);
    return {OPC_MOV, rd, 5'b0, 16'h0000};
  endfunction

  function automatic logic [31:0] add_word(input logic [3:0] rd, input logic [3:0] a,
                                           input logic [3:0] b);
    return {OPC_ADD, rd, a, b, 13'b0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      rs_q    <= '0;
      src_q   <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  assign fire = instr_valid && instr_ready;

  // Termination is tested before each decrement so cnt and k never wrap.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    src_d   = src_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_d  = dest_reg;
            rs_d  = source_reg;
            imm_d = immediate;
            if ((dest_reg == source_reg) && (immediate != '0)) begin
              src_d   = SCR;
              state_d = S_CPY_CLR;
            end else begin
              src_d   = source_reg;
              state_d = S_CLR;
            end
          end
        end
        S_CPY_CLR: if (fire) state_d = S_CPY_ADD;
        S_CPY_ADD: if (fire) state_d = S_CLR;
        S_CLR: begin
          if (fire) begin
            if (imm_q == '0) begin
              state_d = S_DONE;
            end else if (MODE == 0) begin
              cnt_d   = imm_q;
              state_d = S_ADD;
            end else begin
              k_d     = msb_idx(imm_q);
              state_d = S_ACC;
            end
          end
        end
        S_ADD: begin
          if (fire) begin
            if (cnt_q == CNT_ONE) state_d = S_DONE;
            else                  cnt_d   = cnt_q - CNT_ONE;
          end
        end
        S_ACC: begin
          if (fire) begin
            if (k_q == '0) begin
              state_d = S_DONE;
            end else begin
              k_d     = k_q - K_ONE;
              state_d = S_DBL;
            end
          end
        end
        S_DBL: begin
          if (fire) begin
            if (imm_q[k_q])      state_d = S_ACC;
            else if (k_q == '0)  state_d = S_DONE;
            else                 k_d     = k_q - K_ONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    instr_out   = NOP_WORD;
    instr_valid = 1'b0;
    start_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    case (state_q)
      S_CPY_CLR: begin instr_out = mov_word(SCR);              instr_valid = 1'b1; end
      S_CPY_ADD: begin instr_out = add_word(SCR, SCR, rs_q);   instr_valid = 1'b1; end
      S_CLR:     begin instr_out = mov_word(rd_q);             instr_valid = 1'b1; end
      S_ADD,
      S_ACC:     begin instr_out = add_word(rd_q, rd_q, src_q); instr_valid = 1'b1; end
      S_DBL:     begin instr_out = add_word(rd_q, rd_q, rd_q);  instr_valid = 1'b1; end
      default:   ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ucode_mul_seq.sv
`default_nettype none
// tb_ucode_mul_seq: scoreboard bench over a repeated-add and a double-and-add instance
module tb_ucode_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  dest_reg = '0;
  logic [3:0]  source_reg = '0;
  logic [15:0] immediate = '0;
  logic        flush = 1'b0;
  logic        instr_ready = 1'b1;

  logic        sr0, v0, b0, d0, sr1, v1, b1, d1;
  logic [31:0] i0, i1;
  logic        start0, start1;
  logic        m_sr, m_valid, m_busy, m_done;
  logic [31:0] m_instr;

  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  int          nvec = 0;
  int          nerr = 0;

  localparam logic [31:0] NOP = {5'b11001, 27'b0};

  always #5 clk = ~clk;

  assign start0  = start & ~sel;
  assign start1  = start & sel;
  assign m_sr    = sel ? sr1 : sr0;
  assign m_valid = sel ? v1 : v0;
  assign m_busy  = sel ? b1 : b0;
  assign m_done  = sel ? d1 : d0;
  assign m_instr = sel ? i1 : i0;

  ucode_mul_seq #(.IMM_W(16), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .start_ready(sr0),
    .dest_reg(dest_reg), .source_reg(source_reg), .immediate(immediate),
    .flush(flush), .instr_out(i0), .instr_valid(v0), .instr_ready(instr_ready),
    .busy(b0), .done(d0));

  ucode_mul_seq #(.IMM_W(16), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .start_ready(sr1),
    .dest_reg(dest_reg), .source_reg(source_reg), .immediate(immediate),
    .flush(flush), .instr_out(i1), .instr_valid(v1), .instr_ready(instr_ready),
    .busy(b1), .done(d1));

  function automatic logic [31:0] mov(input logic [3:0] rd);
    return {7'b0000000, rd, 5'b0, 16'h0000};
  endfunction

  function automatic logic [31:0] add(input logic [3:0] rd, input logic [3:0] a,
                                      input logic [3:0] b);
    return {7'b0110001, rd, a, b, 13'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted word is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL extra_word: got %h expected none at %0t", m_instr, $time);
      end else begin
        chk("word", m_instr, exp_q.pop_front());
      end
      acc_q.push_back(m_instr);
    end
  end

  task automatic apply_start(input logic s, input logic [3:0] rd, input logic [3:0] rs,
                             input logic [15:0] imm);
    @(posedge clk); #1;
    sel = s; dest_reg = rd; source_reg = rs; immediate = imm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dest_reg = ~rd; source_reg = ~rs; immediate = ~imm;
  endtask

  task automatic wait_done(input int exp_cyc, input int stall_at, input int stall_n,
                           input logic [31:0] stall_word);
    int c = 1;
    bit seen = 0;
    chk("busy_after_accept", {31'b0, m_busy}, 32'd1);
    chk("valid_after_accept", {31'b0, m_valid}, 32'd1);
    while (c < 200 && !seen) begin
      if (m_done) begin
        seen = 1;
      end else begin
        if (c == stall_at) begin
          instr_ready = 1'b0;
          for (int n = 0; n < stall_n; n++) begin
            chk("stall_hold", m_instr, stall_word);
            @(posedge clk); #1; c++;
          end
          instr_ready = 1'b1;
        end
        @(posedge clk); #1; c++;
      end
    end
    if (!seen) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: got no done expected done at cycle %0d", exp_cyc);
    end else begin
      chk("done_cycle", c, exp_cyc);
      chk("done_busy", {31'b0, m_busy}, 32'd1);
      chk("done_valid", {31'b0, m_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("done_pulse_end", {31'b0, m_done}, 32'd0);
    chk("idle_ready", {31'b0, m_sr}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  // Executes the accepted words on a small register file model.
  task automatic exec_check(input logic [3:0] rs, input logic [15:0] rs_val,
                            input logic [3:0] rd, input logic [15:0] exp);
    logic [15:0] rf [16];
    logic [31:0] w;
    for (int r = 0; r < 16; r++) rf[r] = '0;
    rf[rs] = rs_val;
    while (acc_q.size() != 0) begin
      w = acc_q.pop_front();
      if (w[31:25] == 7'b0000000) rf[w[24:21]] = w[15:0];
      else                         rf[w[24:21]] = rf[w[20:17]] + rf[w[16:13]];
    end
    chk("result", {16'b0, rf[rd]}, {16'b0, exp});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_sr0"},    {31'b0, sr0}, 32'd1);
    chk({tag, "_busy0"},  {31'b0, b0},  32'd0);
    chk({tag, "_done0"},  {31'b0, d0},  32'd0);
    chk({tag, "_valid0"}, {31'b0, v0},  32'd0);
    chk({tag, "_instr0"}, i0, NOP);
    chk({tag, "_sr1"},    {31'b0, sr1}, 32'd1);
    chk({tag, "_busy1"},  {31'b0, b1},  32'd0);
    chk({tag, "_valid1"}, {31'b0, v1},  32'd0);
    chk({tag, "_instr1"}, i1, NOP);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;

    // repeated-add, imm=3
    exp_q.push_back(mov(1));
    repeat (3) exp_q.push_back(add(1, 1, 0));
    apply_start(0, 4'd1, 4'd0, 16'd3);
    wait_done(5, 0, 0, 32'h0);
    exec_check(4'd0, 16'd5, 4'd1, 16'd15);

    // repeated-add, imm=0 and imm=1
    exp_q.push_back(mov(1));
    apply_start(0, 4'd1, 4'd0, 16'd0);
    wait_done(2, 0, 0, 32'h0);
    acc_q.delete();
    exp_q.push_back(mov(1));
    exp_q.push_back(add(1, 1, 0));
    apply_start(0, 4'd1, 4'd0, 16'd1);
    wait_done(3, 0, 0, 32'h0);
    exec_check(4'd0, 16'd9, 4'd1, 16'd9);

    // double-and-add, imm=5
    exp_q.push_back(mov(2));
    exp_q.push_back(add(2, 2, 3));
    exp_q.push_back(add(2, 2, 2));
    exp_q.push_back(add(2, 2, 2));
    exp_q.push_back(add(2, 2, 3));
    apply_start(1, 4'd2, 4'd3, 16'd5);
    wait_done(6, 0, 0, 32'h0);
    exec_check(4'd3, 16'd3, 4'd2, 16'd15);

    // aliased double-and-add, Rd=Rs=4, imm=3
    exp_q.push_back(mov(15));
    exp_q.push_back(add(15, 15, 4));
    exp_q.push_back(mov(4));
    exp_q.push_back(add(4, 4, 15));
    exp_q.push_back(add(4, 4, 4));
    exp_q.push_back(add(4, 4, 15));
    apply_start(1, 4'd4, 4'd4, 16'd3);
    wait_done(7, 0, 0, 32'h0);
    exec_check(4'd4, 16'd7, 4'd4, 16'd21);

    // double-and-add, imm=1 and imm=0x8000 (top bit only)
    exp_q.push_back(mov(5));
    exp_q.push_back(add(5, 5, 6));
    apply_start(1, 4'd5, 4'd6, 16'd1);
    wait_done(3, 0, 0, 32'h0);
    acc_q.delete();
    exp_q.push_back(mov(5));
    exp_q.push_back(add(5, 5, 6));
    repeat (15) exp_q.push_back(add(5, 5, 5));
    apply_start(1, 4'd5, 4'd6, 16'h8000);
    wait_done(18, 0, 0, 32'h0);
    exec_check(4'd6, 16'd1, 4'd5, 16'h8000);

    // stall on the second word of a repeated-add imm=2
    exp_q.push_back(mov(1));
    exp_q.push_back(add(1, 1, 0));
    exp_q.push_back(add(1, 1, 0));
    apply_start(0, 4'd1, 4'd0, 16'd2);
    wait_done(7, 2, 3, add(1, 1, 0));
    exec_check(4'd0, 16'd4, 4'd1, 16'd8);

    // start while busy is ignored; flush (with a coincident start) aborts
    exp_q.push_back(mov(1));
    exp_q.push_back(add(1, 1, 0));
    apply_start(0, 4'd1, 4'd0, 16'd5);
    dest_reg = 4'd7; source_reg = 4'd8; immediate = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_ignored", m_instr, add(1, 1, 0));
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", {31'b0, m_busy}, 32'd0);
    chk("flush_sr", {31'b0, m_sr}, 32'd1);
    chk("flush_valid", {31'b0, m_valid}, 32'd0);
    chk("flush_done", {31'b0, m_done}, 32'd0);
    @(posedge clk); #1;
    chk("flush_no_done", {31'b0, m_done}, 32'd0);
    chk("flush_scoreboard", exp_q.size(), 32'd0);
    acc_q.delete();

    // asynchronous reset in the middle of a double-and-add
    exp_q.push_back(mov(2));
    exp_q.push_back(add(2, 2, 3));
    apply_start(1, 4'd2, 4'd3, 16'd5);
    @(posedge clk); #7;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_scoreboard", exp_q.size(), 32'd0);
    acc_q.delete();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
